// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter feeding one registered valid/ready output channel.
// A rotating priority pointer gives fair, starvation-free access at one beat per cycle.
module rr_mux_arbiter #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  input  logic           out_ready
);

  logic [SW-1:0] r_ptr;
  logic          r_outValid;
  logic [W-1:0]  r_outData;
  logic [SW-1:0] r_outSrc;

  logic          w_acc;
  logic          w_any;
  logic [SW-1:0] w_gIdx;
  logic [N-1:0]  w_grant;
  logic [W-1:0]  w_selData;

  // Index reached by stepping offs positions past base, wrapping at N.
  function automatic logic [SW-1:0] wrapIdx(input logic [SW-1:0] base, input int offs);
    int sum;
    sum = (int'(base) + offs) % N;
    return sum[SW-1:0];
  endfunction

  // Held reset keeps in_ready low even though the empty output register could accept.
  assign w_acc = rst_n && (!r_outValid || out_ready);

  always_comb begin
    w_any   = 1'b0;
    w_gIdx  = '0;
    w_grant = '0;
    for (int k = 1; k <= N; k++) begin
      if (!w_any && in_valid[wrapIdx(r_ptr, k)]) begin
        w_any  = 1'b1;
        w_gIdx = wrapIdx(r_ptr, k);
      end
    end
    if (w_any) begin
      w_grant[w_gIdx] = 1'b1;
    end
  end

  assign w_selData = in_data[int'(w_gIdx)*W +: W];
  assign in_ready  = w_acc ? w_grant : '0;

  // The pointer only moves on an accepted transfer, so stalls and idle cycles keep priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= SW'(N - 1);
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSrc   <= '0;
    end else if (w_acc && w_any) begin
      r_ptr      <= w_gIdx;
      r_outValid <= 1'b1;
      r_outData  <= w_selData;
      r_outSrc   <= w_gIdx;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_src   = r_outSrc;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter with N=4, W=8.
// Outputs are sampled 1 time unit after the rising edge; in_ready after inputs settle.
module tb_rr_mux_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N*W-1:0] data,
                               input logic ready);
    in_valid  = valid;
    in_data   = data;
    out_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic expValid, input logic [W-1:0] expData,
                           input logic [SW-1:0] expSrc);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(expValid));
    checkOutput({tag, ".data"},  32'(out_data),  32'(expData));
    checkOutput({tag, ".src"},   32'(out_src),   32'(expSrc));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000, '0, 1'b0);
    #1;
    checkBeat("rst_hold", 1'b0, 8'h00, 2'd0);
    checkOutput("rst_rdy_idle", 32'(in_ready), 32'h0);

    // Requests during reset must not be acknowledged.
    applyStimulus(4'b1111, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 1'b1);
    #1;
    checkOutput("rst_rdy_req", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkBeat("rst_cycle", 1'b0, 8'h00, 2'd0);
      checkOutput("rst_cycle_rdy", 32'(in_ready), 32'h0);
    end

    applyStimulus(4'b0000, '0, 1'b1);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_rdy", 32'(in_ready), 32'h0);
    tick;
    checkBeat("idle", 1'b0, 8'h00, 2'd0);

    $display("[TB] fairness with all requesters valid");
    applyStimulus(4'b1111, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 1'b1);
    #1;
    checkOutput("fair_rdy0", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick;
      checkBeat("fair", 1'b1, 8'(8'hA0 + (i % 4)), 2'(i % 4));
      checkOutput("fair_rdy", 32'(in_ready), 32'(1 << ((i + 1) % 4)));
    end

    applyStimulus(4'b0000, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 1'b1);
    tick;
    checkBeat("drain_after_fair", 1'b0, 8'hA0, 2'd0);

    $display("[TB] backpressure");
    applyStimulus(4'b0110, {8'h00, 8'h22, 8'h11, 8'h00}, 1'b0);
    #1;
    checkOutput("bp_rdy_first", 32'(in_ready), 32'h2);
    tick;
    checkBeat("bp_first", 1'b1, 8'h11, 2'd1);
    applyStimulus(4'b0100, {8'h00, 8'h22, 8'h11, 8'h00}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("bp_stall_rdy", 32'(in_ready), 32'h0);
      tick;
      checkBeat("bp_stall", 1'b1, 8'h11, 2'd1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_rdy", 32'(in_ready), 32'h4);
    tick;
    checkBeat("bp_release", 1'b1, 8'h22, 2'd2);

    $display("[TB] wrap-around priority");
    applyStimulus(4'b1000, {8'h33, 8'h00, 8'h00, 8'h00}, 1'b1);
    #1;
    checkOutput("wrap_rdy3", 32'(in_ready), 32'h8);
    tick;
    checkBeat("wrap_g3", 1'b1, 8'h33, 2'd3);
    applyStimulus(4'b1001, {8'h55, 8'h00, 8'h00, 8'h44}, 1'b1);
    #1;
    checkOutput("wrap_rdy0", 32'(in_ready), 32'h1);
    tick;
    checkBeat("wrap_g0", 1'b1, 8'h44, 2'd0);
    applyStimulus(4'b1000, {8'h55, 8'h00, 8'h00, 8'h44}, 1'b1);
    #1;
    checkOutput("wrap_rdy3b", 32'(in_ready), 32'h8);
    tick;
    checkBeat("wrap_g3b", 1'b1, 8'h55, 2'd3);

    $display("[TB] single beat drain");
    applyStimulus(4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00}, 1'b1);
    #1;
    checkOutput("drain_rdy", 32'(in_ready), 32'h4);
    tick;
    checkBeat("drain_beat", 1'b1, 8'h5A, 2'd2);
    applyStimulus(4'b0000, {8'h00, 8'h5A, 8'h00, 8'h00}, 1'b1);
    tick;
    checkBeat("drain_empty", 1'b0, 8'h5A, 2'd2);
    tick;
    checkBeat("drain_stays", 1'b0, 8'h5A, 2'd2);

    // Lone requester behind the pointer still wins through the wrap.
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'h77, 8'h00}, 1'b1);
    #1;
    checkOutput("single_rdy", 32'(in_ready), 32'h2);
    tick;
    checkBeat("single", 1'b1, 8'h77, 2'd1);

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(4'b0000, {8'h00, 8'h00, 8'h77, 8'h00}, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkBeat("async_rst", 1'b0, 8'h00, 2'd0);
    applyStimulus(4'b1111, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 1'b1);
    #1;
    checkOutput("async_rst_rdy", 32'(in_ready), 32'h0);
    tick;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_rdy", 32'(in_ready), 32'h1);
    tick;
    checkBeat("post_rst_g0", 1'b1, 8'hA0, 2'd0);
    tick;
    checkBeat("post_rst_g1", 1'b1, 8'hA1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
